// File: rtl/gray_pkg.sv
// Shared types and helpers for the pulse-window measurement path.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } gw_state_t;

  localparam int GW_EDGE_STAGES = 2;
  localparam int GW_MAX_W       = 32;

  // Width-generic: callers zero-extend into GW_MAX_W and truncate the result back.
  function automatic logic [GW_MAX_W-1:0] bin2gray(input logic [GW_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Two-stage sampler of a clk-synchronous level; flags a 0->1 transition one cycle later.
module pulse_edge_det
  import gray_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic rise
);

  logic [GW_EDGE_STAGES-1:0] d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d <= '0;
    else     d <= {d[0], pulse};
  end

  assign rise = d[0] & ~d[1];

endmodule

// File: rtl/gray_window_ctrl.sv
// Measurement-window controller: counts pulse rising edges for a programmed
// number of cycles, then presents the frozen count in binary and Gray code.
module gray_window_ctrl
  import gray_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [CNT_W-1:0] bin_count,
  output logic [CNT_W-1:0] gray_count,
  output logic             overflow
);

  gw_state_t        state;
  logic             rise;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;

  pulse_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .pulse (pulse),
    .rise  (rise)
  );

  // cnt_nxt includes the current cycle's edge so the last window cycle is counted.
  assign cnt_nxt = cnt + CNT_W'(rise);
  assign wrap    = rise & (&cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      win        <= '0;
      timer      <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      bin_count  <= '0;
      gray_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
            win   <= (window_len == '0) ? WIN_W'(1) : window_len;
          end
        end
        ARM: begin
          cnt        <= '0;
          timer      <= '0;
          overflow   <= 1'b0;
          bin_count  <= '0;
          gray_count <= '0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          cnt   <= cnt_nxt;
          timer <= timer + WIN_W'(1);
          if (wrap) overflow <= 1'b1;
          // Abort wins over a window that happens to end in the same cycle.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer == win - WIN_W'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            bin_count  <= cnt_nxt;
            gray_count <= CNT_W'(bin2gray(GW_MAX_W'(cnt_nxt)));
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_window_ctrl.sv
// Randomized and directed bench for gray_window_ctrl against a pulse-history model.
module tb_gray_window_ctrl;

  localparam int CNT_W = 4;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             pulse;
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic             abort;
  logic             out_ready;
  logic             busy;
  logic             out_valid;
  logic [CNT_W-1:0] bin_count;
  logic [CNT_W-1:0] gray_count;
  logic             overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit p_hist [0:8191];

  always #5 clk = ~clk;

  gray_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse      (pulse),
    .start      (start),
    .window_len (window_len),
    .abort      (abort),
    .out_ready  (out_ready),
    .busy       (busy),
    .out_valid  (out_valid),
    .bin_count  (bin_count),
    .gray_count (gray_count),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // p_hist[c] is the pulse level sampled at the edge closing cycle c.
  task automatic step();
    p_hist[cyc] = pulse;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic gen(input int mode, input int r);
    case (mode)
      0:       return logic'($urandom_range(0, 1));
      1:       return logic'(r % 2);
      2:       return (r == 3) || (r == 6) || (r == 9);
      3:       return (r == 1);
      4:       return (r >= 2);
      default: return 1'b0;
    endcase
  endfunction

  // One full measurement: start, window, optional backpressure, transfer.
  task automatic measure(input int wlen, input int mode, input int bp, input bit poke);
    int s, n, tot, e_bin, e_gray, e_ovf, vc;
    bit seen;
    chk("idle_busy", busy, 0);
    s = cyc;
    n = (wlen == 0) ? 1 : wlen;
    window_len = WIN_W'(wlen);
    start = 1'b1;
    pulse = gen(mode, 0);
    step();
    start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_valid", out_valid, 0);
    seen = 0;
    vc = 0;
    for (int i = 0; i < n + 8; i++) begin
      if (out_valid) begin
        seen = 1;
        vc = cyc;
        break;
      end
      pulse = gen(mode, cyc - s);
      if (poke) begin
        start = (cyc - s == 4);
        if (cyc - s == 4) window_len = WIN_W'(n + 7);
      end
      step();
    end
    start = 1'b0;
    pulse = 1'b0;
    if (!seen) begin
      chk("vld_timeout", 0, 1);
      return;
    end
    chk("vld_cycle", vc - s, n + 2);
    tot = 0;
    for (int k = s + 1; k <= s + n; k++)
      if (p_hist[k] && !p_hist[k-1]) tot++;
    e_bin  = tot % (1 << CNT_W);
    e_gray = e_bin ^ (e_bin >> 1);
    e_ovf  = (tot >= (1 << CNT_W)) ? 1 : 0;
    chk("bin", bin_count, e_bin);
    chk("gray", gray_count, e_gray);
    chk("ovf", overflow, e_ovf);
    for (int i = 0; i < bp; i++) begin
      abort = (i == 0);
      pulse = logic'($urandom_range(0, 1));
      step();
      abort = 1'b0;
      chk("bp_valid", out_valid, 1);
      chk("bp_bin", bin_count, e_bin);
      chk("bp_gray", gray_count, e_gray);
    end
    pulse = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("xfer_valid", out_valid, 0);
    chk("xfer_busy", busy, 0);
    chk("hold_bin", bin_count, e_bin);
    chk("hold_gray", gray_count, e_gray);
  endtask

  initial begin
    int s;
    bit any_vld;
    rst = 1'b1;
    pulse = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    window_len = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_bin", bin_count, 0);
    chk("rst_gray", gray_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (3) step();

    measure(10, 2, 7, 0);
    chk("basic_bin_c", bin_count, 3);
    chk("basic_gray_c", gray_count, 4'b0010);
    chk("basic_ovf_c", overflow, 0);
    step();

    measure(40, 1, 0, 0);
    chk("wrap_bin_c", bin_count, 4);
    chk("wrap_gray_c", gray_count, 4'b0110);
    chk("wrap_ovf_c", overflow, 1);
    step();

    measure(0, 3, 1, 0);
    chk("zero_bin_c", bin_count, 1);
    step();

    measure(12, 4, 2, 0);
    chk("stretch_bin_c", bin_count, 1);
    step();

    measure(9, 0, 1, 1);

    // Abort in the fifth COUNT cycle.
    step();
    s = cyc;
    window_len = WIN_W'(20);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < s + 6) step();
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    any_vld = 0;
    repeat (25) begin
      step();
      if (out_valid) any_vld = 1;
    end
    chk("abort_no_vld", any_vld, 0);

    // Asynchronous reset between edges, mid-COUNT.
    window_len = WIN_W'(30);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) begin
      pulse = ~pulse;
      step();
    end
    pulse = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_bin", bin_count, 0);
    chk("arst_gray", gray_count, 0);
    chk("arst_ovf", overflow, 0);
    #1;
    rst = 1'b0;
    repeat (3) step();
    measure(15, 1, 0, 0);
    step();

    for (int r = 0; r < 8; r++) begin
      measure($urandom_range(0, 30), 0, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_window_ctrl.md
# gray_window_ctrl

Measurement-window controller for the pulse-counting datapath. On each start command it clears the pulse counter and counts rising edges of `pulse` for a programmable number of clock cycles. It then freezes the result and presents it in both binary and Gray code through a valid/ready handshake. It sits between the control logic that requests a measurement and the downstream consumer, such as a CDC FIFO or a register bank, that takes the Gray-coded count.

## Interface
Parameters:
- `CNT_W`, default 4: width of pulse counter and result outputs.
- `WIN_W`, default 16: width of the window-length input.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pulse`  in  1  pulse input; level, synchronous to `clk`.
- `start`  in  1  measurement request; sampled only in IDLE.
- `window_len`  in  WIN_W  window length in cycles; captured when `start` is accepted.
- `abort`  in  1  cancel the measurement in progress.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in ARM, COUNT and DONE.
- `out_valid`  out  1  result valid; high only in DONE.
- `bin_count`  out  CNT_W  frozen binary edge count.
- `gray_count`  out  CNT_W  frozen Gray code of `bin_count`, computed as `bin ^ (bin >> 1)`.
- `overflow`  out  1  counter wrapped at least once during this window.

## Operation
Edge detector:
- 2-bit shift register `d` loads `{d[0], pulse}` every cycle, in every state.
- `rise = d[0] & ~d[1]`.

State machine (IDLE, ARM, COUNT, DONE):
- **IDLE:**
  - `start=1` → ARM.
  - Capture `window_len` into the window register; if `window_len==0`, load 1 instead.
- **ARM:**
  - Clear the counter, `overflow`, and the window timer.
  - Always lasts exactly one cycle, then → COUNT.
- **COUNT:**
  - Each cycle with `rise=1`: counter += 1.
  - If the counter reaches `2^CNT_W-1` and increments, it wraps to 0 and sets `overflow` (sticky).
  - The timer increments every cycle. When the timer equals window−1, the FSM → DONE.
  - The final cycle's `rise` is still counted.
- **DONE:**
  - `bin_count` and `gray_count` are registered on entry and stay constant.
  - `out_valid=1`.
  - `out_ready=1` → IDLE.
- **abort:**
  - In ARM or COUNT: → IDLE next cycle; `out_valid` never asserts.
  - In IDLE or DONE: ignored.
  - `abort` has priority over the COUNT→DONE transition in the same cycle.
- **start:**
  - Ignored outside IDLE.
  - A `start` held high re-triggers only after the FSM returns to IDLE.

## Timing
- **Reset:** state=IDLE; `d`, counter, timer, `bin_count`, `gray_count`, `overflow`, `out_valid`, `busy` all 0.
- **Start-up sequence:**
  - `start` sampled in cycle 0 → ARM in cycle 1, with `busy=1`.
  - COUNT occupies cycles 2 through N+1, where N is the captured window.
  - DONE from cycle N+2, with `out_valid=1` in that same cycle.
- **Edge latency:** a 0→1 transition of `pulse` sampled at edge k gives `rise=1` during cycle k+1. It is counted only if cycle k+1 is a COUNT cycle.
- **Handshake:**
  - Transfer occurs on a cycle with `out_valid & out_ready`.
  - `out_valid` drops on the next cycle, and `busy` drops with it.
  - A new `start` is accepted no earlier than the cycle after the return to IDLE.
- **Output hold:** outputs hold their last values in IDLE, until the next ARM clears them.
- **Pulse stretch:** a pulse held high for many cycles counts once.
- **Reset mid-operation:** immediate return to IDLE with all outputs at 0, regardless of state.

## Structure
- Shared package `gray_pkg` holds:
  - the state enum `gw_state_t` (IDLE, ARM, COUNT, DONE);
  - function `bin2gray(bin)`, parameterised by width;
  - constant `GW_EDGE_STAGES = 2`.
- One sub-module, `pulse_edge_det`: the 2-stage shift register plus `rise` output, with the same async active-high `rst`. It can be reused by other counters in the design.
- Everything else (FSM, window timer, counter, output registers) lives in `gray_window_ctrl`.

## Test plan
- **Basic count:** reset; `window_len=10`; 3 single-cycle pulses, spaced 2 cycles apart, landing inside COUNT.
  - Expect `out_valid` at cycle 12, `bin_count=3`, `gray_count=4'b0010`, `overflow=0`.
- **Wrap:** `CNT_W=4`, `window_len=40`, pulse toggling every cycle (20 edges).
  - Expect `bin_count=4`, `gray_count=4'b0110`, `overflow=1`.
- **Zero window / boundary edge:** `window_len=0`, with a rise landing in the single COUNT cycle.
  - Expect exactly 1 COUNT cycle, `out_valid` at cycle 3, `bin_count=1`.
- **Abort and start-while-busy:**
  - Abort in the 5th COUNT cycle → IDLE, `out_valid` stays 0, `busy=0` on the next cycle.
  - `start` pulsed during COUNT of a separate run → ignored; the window is unchanged.
- **Handshake backpressure:** hold `out_ready=0` for 7 cycles in DONE.
  - Outputs stable and `out_valid=1` throughout.
  - Raise `out_ready` for 1 cycle → `out_valid=0` the next cycle.
- **Asynchronous reset mid-COUNT:** assert `rst` between clock edges.
  - All outputs 0 immediately.
  - After release, a fresh `start` produces a correct count.
